// File: rtl/adc_dbg_pkg.sv
// Shared types and constants for the 12-bit ADC debug/metering path.
package adc_dbg_pkg;

  localparam int ADC_W = 12;
  localparam logic [ADC_W-1:0] ADC_FS_POS = 12'd2047;

  typedef logic signed [ADC_W-1:0] adc_sample_t;

  // The one code whose magnitude does not fit in ADC_W-1 bits.
  localparam adc_sample_t ADC_FS_NEG = adc_sample_t'(12'h800);

  typedef enum logic {
    ST_HOLD,
    ST_DECAY
  } hold_state_t;

  function automatic logic [ADC_W-1:0] umax(input logic [ADC_W-1:0] a,
                                            input logic [ADC_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/adc_abs_sat.sv
// Registered absolute-value stage: |data| saturated to full scale, forced to
// full scale when the converter flagged out-of-range.
module adc_abs_sat
  import adc_dbg_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  adc_sample_t       data,
  input  logic              otr,
  input  logic              valid,
  output logic [ADC_W-1:0]  mag,
  output logic              mag_otr,
  output logic              mag_valid
);

  logic [ADC_W-1:0] mag_next;
  logic [ADC_W-1:0] mag_reg;
  logic             otr_reg;
  logic             valid_reg;

  always_comb begin
    mag_next = data;
    if (otr || (data == ADC_FS_NEG)) begin
      mag_next = ADC_FS_POS;
    end else if (data[ADC_W-1]) begin
      mag_next = ADC_W'(-data);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mag_reg   <= '0;
      otr_reg   <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      mag_reg   <= mag_next;
      otr_reg   <= otr;
      valid_reg <= valid;
    end
  end

  assign mag       = mag_reg;
  assign mag_otr   = otr_reg;
  assign mag_valid = valid_reg;

endmodule

// File: rtl/adc_peak_hold.sv
// Windowed peak detector: per-window maximum of |sample|, held for a number of
// window closes and then decayed geometrically; OTR is stretched alongside.
module adc_peak_hold
  import adc_dbg_pkg::*;
#(
  parameter int WIN_LOG2     = 16,
  parameter int HOLD_WINDOWS = 8,
  parameter int DECAY_SHIFT  = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  adc_sample_t adc_data,
  input  logic        adc_otr,
  input  logic        sample_en,
  output adc_sample_t peak_data,
  output logic        peak_valid,
  output logic        otr_hold
);

  localparam int CNT_W = $clog2(HOLD_WINDOWS + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_WINDOWS);

  // S1 input register
  adc_sample_t data1_reg;
  logic        otr1_reg;
  logic        v1_reg;

  // S2 outputs
  logic [ADC_W-1:0] mag;
  logic             mag_otr;
  logic             mag_valid;

  // S3 window and hold state
  logic [ADC_W-1:0]    win_max_reg, win_max_next;
  logic                win_otr_reg, win_otr_next;
  logic [WIN_LOG2-1:0] win_cnt_reg, win_cnt_next;
  hold_state_t         state_reg, state_next;
  logic [CNT_W-1:0]    hold_cnt_reg, hold_cnt_next;
  logic [CNT_W-1:0]    otr_cnt_reg, otr_cnt_next;
  logic [ADC_W-1:0]    peak_reg, peak_next;
  logic                peak_valid_reg, peak_valid_next;
  logic                otr_hold_reg, otr_hold_next;

  logic [ADC_W-1:0] wm;
  logic             wo;
  logic             win_close;
  logic [ADC_W-1:0] step;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data1_reg <= '0;
      otr1_reg  <= 1'b0;
      v1_reg    <= 1'b0;
    end else begin
      data1_reg <= adc_data;
      otr1_reg  <= adc_otr;
      v1_reg    <= sample_en;
    end
  end

  adc_abs_sat u_abs_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .data      (data1_reg),
    .otr       (otr1_reg),
    .valid     (v1_reg),
    .mag       (mag),
    .mag_otr   (mag_otr),
    .mag_valid (mag_valid)
  );

  assign wm        = umax(win_max_reg, mag);
  assign wo        = win_otr_reg | mag_otr;
  assign win_close = &win_cnt_reg;

  // Decay step never drops to zero, so small peaks still bleed away.
  always_comb begin
    step = peak_reg >> DECAY_SHIFT;
    if (step == '0) begin
      step = ADC_W'(1);
    end
  end

  always_comb begin
    win_max_next    = win_max_reg;
    win_otr_next    = win_otr_reg;
    win_cnt_next    = win_cnt_reg;
    state_next      = state_reg;
    hold_cnt_next   = hold_cnt_reg;
    otr_cnt_next    = otr_cnt_reg;
    peak_next       = peak_reg;
    peak_valid_next = 1'b0;

    if (mag_valid) begin
      if (win_close) begin
        win_max_next    = '0;
        win_otr_next    = 1'b0;
        win_cnt_next    = '0;
        peak_valid_next = 1'b1;

        if (wm >= peak_reg) begin
          peak_next     = wm;
          hold_cnt_next = HOLD_LOAD;
          state_next    = ST_HOLD;
        end else begin
          case (state_reg)
            ST_HOLD: begin
              if (hold_cnt_reg == CNT_W'(1)) begin
                state_next = ST_DECAY;
              end else begin
                hold_cnt_next = hold_cnt_reg - 1'b1;
              end
            end
            default: begin
              peak_next = umax(wm, peak_reg - step);
            end
          endcase
        end

        if (wo) begin
          otr_cnt_next = HOLD_LOAD;
        end else if (otr_cnt_reg != '0) begin
          otr_cnt_next = otr_cnt_reg - 1'b1;
        end
      end else begin
        win_max_next = wm;
        win_otr_next = wo;
        win_cnt_next = win_cnt_reg + 1'b1;
      end
    end

    otr_hold_next = (otr_cnt_next != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_max_reg    <= '0;
      win_otr_reg    <= 1'b0;
      win_cnt_reg    <= '0;
      state_reg      <= ST_DECAY;
      hold_cnt_reg   <= '0;
      otr_cnt_reg    <= '0;
      peak_reg       <= '0;
      peak_valid_reg <= 1'b0;
      otr_hold_reg   <= 1'b0;
    end else begin
      win_max_reg    <= win_max_next;
      win_otr_reg    <= win_otr_next;
      win_cnt_reg    <= win_cnt_next;
      state_reg      <= state_next;
      hold_cnt_reg   <= hold_cnt_next;
      otr_cnt_reg    <= otr_cnt_next;
      peak_reg       <= peak_next;
      peak_valid_reg <= peak_valid_next;
      otr_hold_reg   <= otr_hold_next;
    end
  end

  assign peak_data  = adc_sample_t'(peak_reg);
  assign peak_valid = peak_valid_reg;
  assign otr_hold   = otr_hold_reg;

endmodule

// File: tb/tb_adc_peak_hold.sv
// Directed bench for adc_peak_hold with 4-sample windows, hold of 2, shift of 2.
module tb_adc_peak_hold;
  import adc_dbg_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  adc_sample_t adc_data = '0;
  logic        adc_otr = 1'b0;
  logic        sample_en = 1'b0;
  adc_sample_t peak_data;
  logic        peak_valid;
  logic        otr_hold;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  adc_peak_hold #(
    .WIN_LOG2     (2),
    .HOLD_WINDOWS (2),
    .DECAY_SHIFT  (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .adc_data   (adc_data),
    .adc_otr    (adc_otr),
    .sample_en  (sample_en),
    .peak_data  (peak_data),
    .peak_valid (peak_valid),
    .otr_hold   (otr_hold)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input logic o, input logic en);
    adc_data  = adc_sample_t'(d);
    adc_otr   = o;
    sample_en = en;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0);
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  // Drives one full window back to back, then two idle cycles; reports the
  // outputs two cycles after the last capture and whether peak_valid fired early.
  task automatic close_window(input int s0, input int s1, input int s2, input int s3,
                              input logic [3:0] otr, output logic early,
                              output logic pv, output int pk, output logic oh);
    int s[4];
    s = '{s0, s1, s2, s3};
    early = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(s[i], otr[i], 1'b1);
      step();
      early |= peak_valid;
    end
    drive(0, 1'b0, 1'b0);
    step();
    early |= peak_valid;
    step();
    pv = peak_valid;
    pk = int'(peak_data);
    oh = otr_hold;
  endtask

  task automatic test_reset();
    logic early, pv, oh;
    int   pk;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1234, 1'b1, 1'b1);
      step();
      n_cmp++;
      if ({peak_data, peak_valid, otr_hold} !== 14'd0) begin
        n_bad++;
        $display("FAIL reset_init[%0d]: got pk=%0d pv=%0b oh=%0b required all 0", i, peak_data, peak_valid, otr_hold);
      end
    end
    rst_n = 1'b1;
    close_window(100, 800, 3, 4, 4'b0001, early, pv, pk, oh);
    n_cmp++;
    if (pk !== 2047 || oh !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_prewin: got pk=%0d oh=%0b required 2047/1", pk, oh);
    end
    drive(1900, 1'b0, 1'b1);
    repeat (2) step();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if ({peak_data, peak_valid, otr_hold} !== 14'd0) begin
        n_bad++;
        $display("FAIL reset_mid[%0d]: got pk=%0d pv=%0b oh=%0b required all 0", i, peak_data, peak_valid, otr_hold);
      end
    end
    rst_n = 1'b1;
    drive(0, 1'b0, 1'b0);
    close_window(5, 5, 5, 5, 4'b0000, early, pv, pk, oh);
    n_cmp++;
    if (early !== 1'b0 || pv !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_first_close: got early=%0b pv=%0b required 0/1", early, pv);
    end
    n_cmp++;
    if (pk !== 5 || oh !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_first_peak: got pk=%0d oh=%0b required 5/0", pk, oh);
    end
  endtask

  task automatic test_basic();
    logic early, pv, oh;
    int   pk;
    close_window(100, -300, 50, 7, 4'b0000, early, pv, pk, oh);
    n_cmp++;
    if (early !== 1'b0 || pv !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_valid: got early=%0b pv=%0b required 0/1", early, pv);
    end
    n_cmp++;
    if (pk !== 300) begin
      n_bad++;
      $display("FAIL basic_peak: got %0d required 300", pk);
    end
    step();
    n_cmp++;
    if (peak_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_pulse_width: got pv=%0b required 0", peak_valid);
    end
  endtask

  task automatic test_saturation();
    logic early, pv, oh;
    int   pk;
    close_window(-5, -2048, 2000, 1, 4'b0000, early, pv, pk, oh);
    n_cmp++;
    if (pv !== 1'b1 || pk !== 2047) begin
      n_bad++;
      $display("FAIL saturation: got pv=%0b pk=%0d required 1/2047", pv, pk);
    end
  endtask

  task automatic test_hold_decay();
    logic early, pv, oh;
    int   pk;
    int   exp_pk[6] = '{1000, 1000, 1000, 750, 563, 423};
    do_reset();
    for (int w = 0; w < 6; w++) begin
      if (w == 0) close_window(10, 1000, -20, 0, 4'b0000, early, pv, pk, oh);
      else        close_window(0, 0, 0, 0, 4'b0000, early, pv, pk, oh);
      n_cmp++;
      if (pv !== 1'b1 || pk !== exp_pk[w]) begin
        n_bad++;
        $display("FAIL hold_decay[%0d]: got pv=%0b pk=%0d required 1/%0d", w, pv, pk, exp_pk[w]);
      end
    end
  endtask

  task automatic test_min_step();
    logic early, pv, oh;
    int   pk;
    int   exp_pk[6] = '{3, 3, 3, 2, 1, 0};
    do_reset();
    for (int w = 0; w < 6; w++) begin
      if (w == 0) close_window(3, 0, -1, 2, 4'b0000, early, pv, pk, oh);
      else        close_window(0, 0, 0, 0, 4'b0000, early, pv, pk, oh);
      n_cmp++;
      if (pk !== exp_pk[w]) begin
        n_bad++;
        $display("FAIL min_step[%0d]: got %0d required %0d", w, pk, exp_pk[w]);
      end
    end
  endtask

  task automatic test_otr();
    logic early, pv, oh;
    int   pk;
    logic exp_oh[3] = '{1'b1, 1'b1, 1'b0};
    do_reset();
    for (int w = 0; w < 3; w++) begin
      if (w == 0) close_window(10, 20, 30, 40, 4'b0010, early, pv, pk, oh);
      else        close_window(1, 2, 3, 4, 4'b0000, early, pv, pk, oh);
      n_cmp++;
      if (oh !== exp_oh[w]) begin
        n_bad++;
        $display("FAIL otr_hold[%0d]: got %0b required %0b", w, oh, exp_oh[w]);
      end
      if (w == 0) begin
        n_cmp++;
        if (pk !== 2047) begin
          n_bad++;
          $display("FAIL otr_peak: got %0d required 2047", pk);
        end
      end
    end
  endtask

  task automatic test_gaps();
    logic early;
    do_reset();
    early = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1500, 1'b0, 1'b0);
      step();
      early |= peak_valid;
      drive(10 * (i + 1), 1'b0, 1'b1);
      step();
      early |= peak_valid;
    end
    drive(1500, 1'b0, 1'b0);
    step();
    early |= peak_valid;
    step();
    n_cmp++;
    if (early !== 1'b0 || peak_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL gaps_close: got early=%0b pv=%0b required 0/1", early, peak_valid);
    end
    n_cmp++;
    if (peak_data !== adc_sample_t'(40)) begin
      n_bad++;
      $display("FAIL gaps_peak: got %0d required 40", peak_data);
    end
  endtask

  task automatic test_back_to_back();
    int        s[8] = '{100, 600, 200, 300, 900, 50, 60, 70};
    logic [9:0] pv_seq;
    do_reset();
    pv_seq = '0;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) drive(s[i], 1'b0, 1'b1);
      else       drive(0, 1'b0, 1'b0);
      step();
      pv_seq[i] = peak_valid;
    end
    n_cmp++;
    if (pv_seq !== 10'b10_0010_0000) begin
      n_bad++;
      $display("FAIL b2b_pulses: got %b required %b", pv_seq, 10'b10_0010_0000);
    end
    n_cmp++;
    if (peak_data !== adc_sample_t'(900)) begin
      n_bad++;
      $display("FAIL b2b_peak: got %0d required 900", peak_data);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_hold_decay();
    test_min_step();
    test_otr();
    test_gaps();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
